uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_rx_os.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_os.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 8 data bits, LSB first, one stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data and stop bits.
module uart_rx_os #(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rec_en,
    input  logic       rxd,
    output logic [7:0] rec_dout,
    output logic       rec_valid,
    output logic       rec_busy,
    output logic       frame_err,
    output logic       parity_err,
    output logic [2:0] state_dbg
);

    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT = BAUD_CNT / 2;
    localparam int CW       = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] LAST_C = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] MID_C  = CW'(HALF_CNT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    dout_n;
    logic          valid_n, ferr_n;
    logic          rxd_s1, rxd_s2, rxd_d;

`ifdef UART_RX_PARITY_EN
    logic          par_bad, par_n;
    logic          perr_q, perr_n;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rec_dout  <= 8'h00;
            rec_valid <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_n;
            shift     <= shift_n;
            rec_dout  <= dout_n;
            rec_valid <= valid_n;
            frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_n;
            perr_q    <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_idx;
        shift_n = shift;
        dout_n  = rec_dout;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bad;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rec_en && rxd_d && !rxd_s2) begin
                    state_n = START;
                    bit_n   = 3'd0;
`ifdef UART_RX_PARITY_EN
                    par_n   = 1'b0;
`endif
                end
            end
            // After the start-bit midpoint the counter is realigned so every
            // later sample falls one full bit period after the previous one.
            START: begin
                if (cnt == MID_C) begin
                    cnt_n   = '0;
                    state_n = rxd_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST_C) begin
                    cnt_n   = '0;
                    shift_n = {rxd_s2, shift[7:1]};
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt == LAST_C) begin
                    cnt_n   = '0;
                    par_n   = (^shift) ^ rxd_s2;
                    state_n = STOP;
                end
`else
                state_n = IDLE;
`endif
            end
            STOP: begin
                if (cnt == LAST_C) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (!rxd_s2) begin
                        ferr_n = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad) begin
                        perr_n = 1'b1;
                    end
`endif
                    else begin
                        valid_n = 1'b1;
                        dout_n  = shift;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rec_busy  = (state != IDLE);
    assign state_dbg = state;

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at default clock/baud; frames are driven bit by bit on rxd.
// Honours UART_RX_PARITY_EN by inserting the parity bit and running the parity-error case.
module tb_uart_rx_os;

    localparam int CLK_FREQ = 50000000;
    localparam int UART_BPS = 115200;
    localparam int BAUD     = CLK_FREQ / UART_BPS;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MIN  = 4123 + BAUD;
`else
    localparam int LAT_MIN  = 4123;
`endif
    localparam int LAT_MAX  = LAT_MIN + 8;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       rec_en;
    logic       rxd;
    logic [7:0] rec_dout;
    logic       rec_valid;
    logic       rec_busy;
    logic       frame_err;
    logic       parity_err;
    logic [2:0] state_dbg;

    uart_rx_os #(
        .CLK_FREQ(CLK_FREQ),
        .UART_BPS(UART_BPS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rec_en    (rec_en),
        .rxd       (rxd),
        .rec_dout  (rec_dout),
        .rec_valid (rec_valid),
        .rec_busy  (rec_busy),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // monitor: sampled on the falling edge, away from the active edge
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0, both_cnt = 0, width_err = 0;
    int busy_cycles = 0, last_valid_cyc = 0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0, prev_perr = 1'b0;

    always @(negedge sys_clk) begin
        if (rec_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            got_q.push_back(rec_dout);
        end
        if (frame_err)  ferr_cnt <= ferr_cnt + 1;
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (rec_valid && frame_err) both_cnt <= both_cnt + 1;
        if ((rec_valid && prev_valid) || (frame_err && prev_ferr) || (parity_err && prev_perr))
            width_err <= width_err + 1;
        if (rec_busy) busy_cycles <= busy_cycles + 1;
        prev_valid <= rec_valid;
        prev_ferr  <= frame_err;
        prev_perr  <= parity_err;
    end

    int checks = 0;
    int failures = 0;
    int rd_idx = 0;
    int busy_lows = 0;
    int frame_start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // scoreboard: every expected byte must match the next byte the monitor captured
    task automatic sb_drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < got_q.size()) begin
                check(tag, {24'd0, got_q[rd_idx]}, {24'd0, e});
                rd_idx++;
            end else begin
                check({tag, "_count"}, got_q.size(), rd_idx + 1 + exp_q.size());
                exp_q.delete();
            end
        end
        check({tag, "_extra"}, got_q.size(), rd_idx);
    endtask

    // driver: one frame; drop_en_at / abort_at are bit indices (start bit = 0), -1 for none
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip,
                              input int drop_en_at, input int abort_at);
        logic [10:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
        bits[9]  = (^data) ^ par_flip;
        bits[10] = stop_bit;
        n = 11;
`else
        bits[9] = stop_bit;
        n = 10;
        if (par_flip) n = 10;
`endif
        frame_start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            if (i == drop_en_at) rec_en = 1'b0;
            rxd = bits[i];
            if (i == abort_at) begin
                idle(BAUD / 2);
                check("abort_busy_before", {31'd0, rec_busy}, 32'd1);
                sys_rst_n = 1'b0;
                #1;
                check("abort_rst_dout", {24'd0, rec_dout}, 32'h00);
                check("abort_rst_busy", {31'd0, rec_busy}, 32'd0);
                check("abort_rst_state", {29'd0, state_dbg}, 32'd0);
                idle(5);
                rxd = 1'b1;
                idle(2);
                sys_rst_n = 1'b1;
                return;
            end
            for (int c = 0; c < BAUD; c++) begin
                @(posedge sys_clk);
                #1;
                if (i >= 1 && i <= 8 && c == BAUD / 2 && !rec_busy) busy_lows++;
            end
        end
        rxd = 1'b1;
    endtask

    int v0, f0, p0, b0;

    task automatic snap();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
        b0 = busy_cycles;
        busy_lows = 0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rec_en    = 1'b0;
        rxd       = 1'b1;
        idle(3);
        check("rst_dout",   {24'd0, rec_dout},   32'h00);
        check("rst_valid",  {31'd0, rec_valid},  32'd0);
        check("rst_busy",   {31'd0, rec_busy},   32'd0);
        check("rst_ferr",   {31'd0, frame_err},  32'd0);
        check("rst_perr",   {31'd0, parity_err}, 32'd0);
        check("rst_state",  {29'd0, state_dbg},  32'd0);
        sys_rst_n = 1'b1;
        rec_en = 1'b1;
        idle(20);

        // single good frame, latency and busy
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
        exp_q.push_back(8'hA5);
        idle(50);
        check("a5_valid_cnt", valid_cnt - v0, 1);
        check("a5_dout", {24'd0, rec_dout}, 32'hA5);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_busy_lows", busy_lows, 0);
        check("a5_latency_ok",
              ((last_valid_cyc - frame_start_cyc) >= LAT_MIN &&
               (last_valid_cyc - frame_start_cyc) <= LAT_MAX) ? 32'd1 : 32'd0, 32'd1);
        sb_drain("a5_sb");

        // 200-cycle glitch: false start
        snap();
        rxd = 1'b0;
        idle(200);
        rxd = 1'b1;
        idle(600);
        check("glitch_busy_len_ok",
              ((busy_cycles - b0) >= 210 && (busy_cycles - b0) <= 225) ? 32'd1 : 32'd0, 32'd1);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_end", {31'd0, rec_busy}, 32'd0);

        // good 0x11 then 0x3C with a low stop bit
        snap();
        send_frame(8'h11, 1'b1, 1'b0, -1, -1);
        exp_q.push_back(8'h11);
        idle(100);
        send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
        idle(100);
        check("ferr_cnt", ferr_cnt - f0, 1);
        check("ferr_valid_cnt", valid_cnt - v0, 1);
        check("ferr_dout_kept", {24'd0, rec_dout}, 32'h11);
        sb_drain("ferr_sb");

        // back-to-back, no idle gap
        snap();
        send_frame(8'h00, 1'b1, 1'b0, -1, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        idle(100);
        check("b2b_valid_cnt", valid_cnt - v0, 2);
        check("b2b_dout", {24'd0, rec_dout}, 32'hFF);
        sb_drain("b2b_sb");

        // receive disabled
        snap();
        rec_en = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0, -1, -1);
        idle(100);
        check("dis_busy_cycles", busy_cycles - b0, 0);
        check("dis_valid", valid_cnt - v0, 0);
        check("dis_ferr", ferr_cnt - f0, 0);

        // enable dropped mid-frame
        snap();
        rec_en = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0, 3, -1);
        exp_q.push_back(8'h55);
        idle(100);
        check("drop_valid_cnt", valid_cnt - v0, 1);
        check("drop_dout", {24'd0, rec_dout}, 32'h55);
        sb_drain("drop_sb");
        rec_en = 1'b1;
        idle(20);

        // reset during data bit 4 of 0x99, then a complete 0x42
        snap();
        send_frame(8'h99, 1'b1, 1'b0, -1, 5);
        idle(1000);
        check("abort_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_frame(8'h42, 1'b1, 1'b0, -1, -1);
        exp_q.push_back(8'h42);
        idle(100);
        check("abort_valid_cnt", valid_cnt - v0, 1);
        check("abort_dout", {24'd0, rec_dout}, 32'h42);
        sb_drain("abort_sb");

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h42, 1'b1, 1'b1, -1, -1);
        idle(100);
        check("par_perr_cnt", perr_cnt - p0, 1);
        check("par_valid_cnt", valid_cnt - v0, 0);
        check("par_ferr_cnt", ferr_cnt - f0, 0);
        sb_drain("par_sb");
`else
        check("noparity_perr_cnt", perr_cnt, 0);
`endif

        check("valid_ferr_overlap", both_cnt, 0);
        check("pulse_width", width_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
